// File: rtl/dd_ram_bank_pkg.sv
// ----------------------------------------------------------------------------
// dd_ram_pkg
// Shared definitions for the dd_ram_bank RAM bank:
//   state_e  - controller states (IDLE: serving requests, CLEAR: zeroing sweep)
//   ch_off() - bit offset of channel c inside a packed multi-channel word
// ----------------------------------------------------------------------------
package dd_ram_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_e;

   function automatic int unsigned ch_off(input int unsigned c, input int unsigned w);
      return c * w;
   endfunction

endpackage

// File: rtl/dd_ram_bank_if.sv
// ----------------------------------------------------------------------------
// dd_ram_bank_if
// Request/response/clear bundle of the dd_ram_bank.
//   req_valid/req_ready  valid/ready request handshake
//   req_we               1 = write, 0 = read
//   req_addr             word address (ADDR_W bits)
//   req_wdata/req_wmask  packed write data, one write-enable bit per channel
//   rsp_valid/rsp_rdata  registered read response (one-cycle valid pulse)
//   clear_start/busy     full-array zeroing request and sweep status
// master = requester, slave = RAM bank.
// ----------------------------------------------------------------------------
interface dd_ram_bank_if #(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 4,
   parameter int CHANNELS = 2
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_W-1:0]         req_addr;
   logic [CHANNELS*WIDTH-1:0] req_wdata;
   logic [CHANNELS-1:0]       req_wmask;
   logic                      rsp_valid;
   logic [CHANNELS*WIDTH-1:0] rsp_rdata;
   logic                      clear_start;
   logic                      clear_busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask, clear_start,
      input  req_ready, rsp_valid, rsp_rdata, clear_busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask, clear_start,
      output req_ready, rsp_valid, rsp_rdata, clear_busy
   );

endinterface

// File: rtl/dd_ram_bank_word.sv
// ----------------------------------------------------------------------------
// dd_ram_word
// One WIDTH-bit storage register (one channel of one word).
//   clk, rst_n  clock, asynchronous active-low reset (clears to 0)
//   we_i        word write enable
//   mask_i      channel write enable; register loads only when both are set
//   wdata_i     data to load
//   rdata_o     current contents
// ----------------------------------------------------------------------------
module dd_ram_word #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic             mask_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] data_q, data_d;

   always_comb begin
      data_d = data_q;
      if (we_i && mask_i) data_d = wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
   end

   assign rdata_o = data_q;

endmodule

// File: rtl/dd_ram_bank.sv
// ----------------------------------------------------------------------------
// dd_ram_bank
// DEPTH-word x CHANNELS-lane RAM, all lanes sharing one address, with
// per-lane write masks, a 1-cycle registered read response and a built-in
// clear sequencer that zeroes every word in DEPTH cycles.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         dd_ram_bank_if slave modport (request, response, clear)
// ----------------------------------------------------------------------------
module dd_ram_bank
   import dd_ram_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int DEPTH    = 4,
   parameter int CHANNELS = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   dd_ram_bank_if.slave bus
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int DW     = CHANNELS * WIDTH;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                req_ready;
   logic                clear_busy;
   logic                accept;
   logic                wr_acc;
   logic [WIDTH-1:0]    word_rd [DEPTH][CHANNELS];

   // Controller: clear_start wins over a same-cycle request in IDLE.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      req_ready  = 1'b0;
      clear_busy = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = ~bus.clear_start;
            if (bus.clear_start) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end
         end
         CLEAR: begin
            clear_busy = 1'b1;
            ptr_d      = ptr_q + 1'b1;
            if (ptr_q == ADDR_W'(DEPTH - 1)) begin
               state_d = IDLE;
               ptr_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign accept = bus.req_valid & req_ready;
   assign wr_acc = accept & bus.req_we;

   // Storage array; during a sweep the pointed word is written with zeros on
   // every lane, otherwise the address decoder drives the word enable.
   for (genvar w = 0; w < DEPTH; w++) begin : g_word
      logic word_we;
      assign word_we = clear_busy ? (ptr_q == ADDR_W'(w))
                                  : (wr_acc && (bus.req_addr == ADDR_W'(w)));
      for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
         logic             lane_mask;
         logic [WIDTH-1:0] lane_wdata;
         assign lane_mask  = clear_busy | bus.req_wmask[c];
         assign lane_wdata = clear_busy ? '0 : bus.req_wdata[ch_off(c, WIDTH) +: WIDTH];
         dd_ram_word #(.WIDTH(WIDTH)) u_word (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_i    (word_we),
            .mask_i  (lane_mask),
            .wdata_i (lane_wdata),
            .rdata_o (word_rd[w][c])
         );
      end
   end

   // Read mux and response register; rdata holds until the next accepted read.
   always_comb begin
      rsp_valid_d = accept & ~bus.req_we;
      rsp_rdata_d = rsp_rdata_q;
      if (rsp_valid_d) begin
         for (int c = 0; c < CHANNELS; c++) begin
            rsp_rdata_d[ch_off(c, WIDTH) +: WIDTH] = word_rd[bus.req_addr][c];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign bus.req_ready  = req_ready;
   assign bus.clear_busy = clear_busy;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_dd_ram_bank.sv
// ----------------------------------------------------------------------------
// tb_dd_ram_bank
// Directed bench for dd_ram_bank: a default 4x4x2 instance and an 8x16x4
// instance share one stimulus bus; 'sel' picks the instance under test.
// A reference memory + controller model predicts req_ready, clear_busy and
// the read data; expected read data is queued when a read is accepted and
// popped when the response is due.
// ----------------------------------------------------------------------------
module tb_dd_ram_bank;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        sel = 1'b0;
   logic        s_valid = 1'b0, s_we = 1'b0, s_clear = 1'b0;
   logic [3:0]  s_addr = '0;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wmask = '0;

   dd_ram_bank_if #(.WIDTH(4), .DEPTH(4),  .CHANNELS(2)) ifa ();
   dd_ram_bank_if #(.WIDTH(8), .DEPTH(16), .CHANNELS(4)) ifb ();

   assign ifa.req_valid   = s_valid & ~sel;
   assign ifa.req_we      = s_we;
   assign ifa.req_addr    = s_addr[1:0];
   assign ifa.req_wdata   = s_wdata[7:0];
   assign ifa.req_wmask   = s_wmask[1:0];
   assign ifa.clear_start = s_clear & ~sel;

   assign ifb.req_valid   = s_valid & sel;
   assign ifb.req_we      = s_we;
   assign ifb.req_addr    = s_addr;
   assign ifb.req_wdata   = s_wdata;
   assign ifb.req_wmask   = s_wmask;
   assign ifb.clear_start = s_clear & sel;

   dd_ram_bank #(.WIDTH(4), .DEPTH(4), .CHANNELS(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   dd_ram_bank #(.WIDTH(8), .DEPTH(16), .CHANNELS(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   logic        obs_ready, obs_valid, obs_busy;
   logic [31:0] obs_rdata;
   always_comb begin
      if (sel) begin
         obs_ready = ifb.req_ready;
         obs_valid = ifb.rsp_valid;
         obs_busy  = ifb.clear_busy;
         obs_rdata = ifb.rsp_rdata;
      end else begin
         obs_ready = ifa.req_ready;
         obs_valid = ifa.rsp_valid;
         obs_busy  = ifa.clear_busy;
         obs_rdata = {24'h0, ifa.rsp_rdata};
      end
   end

   // Reference model of the selected instance
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] mdl [16];
   logic [31:0] exp_q [$];
   int          dep_m = 4, w_m = 4, ch_m = 2;
   bit          busy_m = 1'b0;
   int          ptr_m = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mdl[i] = '0;
      exp_q.delete();
      busy_m = 1'b0;
      ptr_m  = 0;
   endtask

   // One clock cycle: drive, check ready, advance model, check post-edge state.
   task automatic cyc(input bit v, input bit we, input int a, input logic [31:0] wd,
                      input logic [3:0] m, input bit clr);
      bit exp_rdy, acc, pushed;
      s_valid = v; s_we = we; s_addr = a[3:0]; s_wdata = wd; s_wmask = m; s_clear = clr;
      #1;
      exp_rdy = !busy_m && !clr;
      chk("req_ready", {31'h0, obs_ready}, {31'h0, exp_rdy});
      acc = v && exp_rdy;
      pushed = 1'b0;
      if (acc && !we) begin
         exp_q.push_back(mdl[a]);
         pushed = 1'b1;
      end
      if (acc && we) begin
         for (int b = 0; b < w_m * ch_m; b++) if (m[b / w_m]) mdl[a][b] = wd[b];
      end
      if (busy_m) begin
         mdl[ptr_m] = '0;
         if (ptr_m == dep_m - 1) begin busy_m = 1'b0; ptr_m = 0; end
         else ptr_m++;
      end else if (clr) begin
         busy_m = 1'b1;
         ptr_m  = 0;
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_clear = 1'b0;
      chk("rsp_valid", {31'h0, obs_valid}, {31'h0, pushed});
      if (pushed) chk("rsp_rdata", obs_rdata, exp_q.pop_front());
      chk("clear_busy", {31'h0, obs_busy}, {31'h0, busy_m});
   endtask

   task automatic wr(input int a, input logic [31:0] wd, input logic [3:0] m);
      cyc(1'b1, 1'b1, a, wd, m, 1'b0);
   endtask

   task automatic rd(input int a);
      cyc(1'b1, 1'b0, a, '0, '0, 1'b0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 0, '0, '0, 1'b0);
   endtask

   initial begin
      int cnt;
      model_reset();

      // Reset state
      #2;
      chk("rst_rsp_valid",  {31'h0, obs_valid}, 32'h0);
      chk("rst_rsp_rdata",  obs_rdata, 32'h0);
      chk("rst_clear_busy", {31'h0, obs_busy}, 32'h0);
      chk("rst_req_ready",  {31'h0, obs_ready}, 32'h1);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Defaults: lane A=1010, lane B=0101
      wr(0, 32'h5A, 4'b0011);
      rd(0);
      chk("default_word0", obs_rdata, 32'h5A);
      idle();
      chk("rsp_one_pulse", {31'h0, obs_valid}, 32'h0);
      chk("rdata_holds", obs_rdata, 32'h5A);

      // Masked write: only lane 0 updated
      wr(1, 32'hF0, 4'b0011);
      wr(1, 32'h3C, 4'b0001);
      rd(1);
      chk("masked_word1", obs_rdata, 32'hFC);

      // Write then read next cycle, then four back-to-back reads
      wr(2, 32'hC3, 4'b0011);
      rd(2);
      chk("wr_then_rd", obs_rdata, 32'hC3);
      wr(3, 32'h96, 4'b0011);
      for (int a = 0; a < 4; a++) rd(a);

      // Clear with a colliding read request; then sweep length
      rd(3);
      cyc(1'b1, 1'b0, 2, '0, '0, 1'b1);
      cnt = 1;
      for (int i = 0; i < 6; i++) begin
         idle();
         if (obs_busy) cnt++;
      end
      chk("clear_len_4", cnt, 32'd4);
      for (int a = 0; a < 4; a++) rd(a);
      chk("cleared_word3", obs_rdata, 32'h0);

      // Reset during the clear sweep
      for (int a = 0; a < 4; a++) wr(a, 32'h11 * (a + 1), 4'b0011);
      rd(3);
      cyc(1'b0, 1'b0, 0, '0, '0, 1'b1);
      idle();
      rst_n = 1'b0;
      #1;
      chk("midclr_busy",  {31'h0, obs_busy}, 32'h0);
      chk("midclr_valid", {31'h0, obs_valid}, 32'h0);
      chk("midclr_rdata", obs_rdata, 32'h0);
      model_reset();
      #3 rst_n = 1'b1;
      for (int a = 0; a < 4; a++) rd(a);

      // Wide instance: 8-bit lanes, 16 words, 4 channels
      sel = 1'b1;
      dep_m = 16; w_m = 8; ch_m = 4;
      model_reset();
      idle();
      for (int a = 0; a < 16; a++)
         wr(a, {8'(a * 17), 8'(~a), 8'(a ^ 8'h55), 8'(a + 1)}, 4'hF);
      for (int a = 0; a < 16; a++) rd(a);
      chk("wide_word15", obs_rdata, 32'hFFF05A10);
      wr(5, 32'hDEADBEEF, 4'b1010);
      rd(5);
      chk("wide_masked5", obs_rdata, 32'hDEFABE06);
      rd(7);
      cyc(1'b0, 1'b0, 0, '0, '0, 1'b1);
      cnt = 1;
      for (int i = 0; i < 18; i++) begin
         idle();
         if (obs_busy) cnt++;
      end
      chk("clear_len_16", cnt, 32'd16);
      for (int a = 0; a < 16; a += 5) rd(a);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
